// File: rtl/md_ctrl_pkg.sv
// md_ctrl shared definitions: MD op encodings,
// multi-cycle latencies and op-class helper.
package md_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    function automatic logic is_long_op(
        input logic [3:0] op
    );
        return op inside {MD_MULT, MD_MULTU,
                          MD_DIV, MD_DIVU};
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit multiply / divide.
// res_o = {HI, LO}; dz_o flags a zero divisor.
module md_arith
    import md_ctrl_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o,
    output logic        dz_o
);

    logic        ovf;
    logic [31:0] sdb;
    logic [31:0] udb;
    logic [63:0] sp;
    logic [63:0] up;
    logic [31:0] sq_raw;
    logic [31:0] sr_raw;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;

    assign dz_o = (b_i == 32'd0);

    // -2^31 / -1 overflows 32 bits; forced result,
    // and divisors swapped to 1 so no operator traps
    assign ovf = (a_i == 32'h8000_0000) &&
                 (b_i == 32'hFFFF_FFFF);
    assign sdb = (dz_o || ovf) ? 32'd1 : b_i;
    assign udb = dz_o ? 32'd1 : b_i;

    assign sp = $signed({{32{a_i[31]}}, a_i}) *
                $signed({{32{b_i[31]}}, b_i});
    assign up = {32'd0, a_i} * {32'd0, b_i};

    assign sq_raw = $signed(a_i) / $signed(sdb);
    assign sr_raw = $signed(a_i) % $signed(sdb);
    assign sq = ovf ? 32'h8000_0000 : sq_raw;
    assign sr = ovf ? 32'd0 : sr_raw;

    assign uq = a_i / udb;
    assign ur = a_i % udb;

    always_comb begin
        res_o = '0;
        case (op_i)
            MD_MULT:  res_o = sp;
            MD_MULTU: res_o = up;
            MD_DIV:   res_o = {sr, sq};
            MD_DIVU:  res_o = {ur, uq};
            default:  res_o = '0;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO multiply-divide unit control.
// MD_CTRL_LATENCY_EN enables 5/10-cycle busy latency.
module md_ctrl
    import md_ctrl_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    input  logic        DUseMD,
    output logic        Busy,
    output logic        MDStall,
    output logic [31:0] HiloOut
);

    logic [31:0] hi_q;
    logic [31:0] hi_d;
    logic [31:0] lo_q;
    logic [31:0] lo_d;
    logic [63:0] res;
    logic        dz;
    logic        is_div;
    logic        is_long;
    logic        go;
    logic        wr_ok;
    logic [31:0] wr_hi;
    logic [31:0] wr_lo;

    md_arith u_arith (
        .op_i  (MDOp),
        .a_i   (A),
        .b_i   (B),
        .res_o (res),
        .dz_o  (dz)
    );

    assign is_div  = (MDOp == MD_DIV) ||
                     (MDOp == MD_DIVU);
    assign is_long = is_long_op(MDOp);
    assign go      = Start & ~Req & ~Busy;

    // divide by zero re-commits the current HI/LO
    assign wr_ok = ~(is_div & dz);
    assign wr_hi = wr_ok ? res[63:32] : hi_q;
    assign wr_lo = wr_ok ? res[31:0]  : lo_q;

`ifdef MD_CTRL_LATENCY_EN
    logic        is_mul;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [31:0] shi_q;
    logic [31:0] shi_d;
    logic [31:0] slo_q;
    logic [31:0] slo_d;

    assign is_mul  = (MDOp == MD_MULT) ||
                     (MDOp == MD_MULTU);
    assign Busy    = (cnt_q != 4'd0);
    assign MDStall = DUseMD &
                     (Busy | (Start & is_long));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
            shi_q <= '0;
            slo_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            shi_q <= shi_d;
            slo_q <= slo_d;
        end
    end
`else
    assign Busy    = 1'b0;
    assign MDStall = 1'b0;
`endif

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
`ifdef MD_CTRL_LATENCY_EN
        cnt_d = cnt_q;
        shi_d = shi_q;
        slo_d = slo_q;
        if (Busy) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d = shi_q;
                lo_d = slo_q;
            end
        end else if (go && is_long) begin
            cnt_d = is_mul ? MULT_CYCLES
                           : DIV_CYCLES;
            shi_d = wr_hi;
            slo_d = wr_lo;
        end
`else
        if (go && is_long) begin
            hi_d = wr_hi;
            lo_d = wr_lo;
        end
`endif
        if (go && (MDOp == MD_MTHI)) begin
            hi_d = A;
        end
        if (go && (MDOp == MD_MTLO)) begin
            lo_d = A;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_comb begin
        HiloOut = '0;
        case (MDOp)
            MD_MFHI: HiloOut = hi_q;
            MD_MFLO: HiloOut = lo_q;
            default: HiloOut = '0;
        endcase
    end

endmodule
